ahb2_arbiter: RTL and testbench

- Arbiter for an AHB2 bus that lets up to N_MST masters share one slave path.
- Drives per-master hgrant and the address-phase and data-phase owner indices (hmaster, hmaster_d).
- The bus address/data multiplexers select on hmaster and hmaster_d.
- Holds grant for the full length of fixed-length bursts and for locked transfers.
- Uses round-robin priority with a parked default master.

---
 rtl/ahb2_arbiter.sv | 141 ++++++++++++++
 tb/tb_ahb2_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ahb2_arbiter.sv
// ahb2_arbiter: round-robin AHB2 bus arbiter with burst/lock hold and a parked
// default master.
//
// Ports:
//   clk, rst_n   - bus clock, synchronous active-low reset
//   hbusreq      - per-master bus request
//   hlock        - per-master lock request
//   htrans       - muxed address-phase htrans (IDLE/BUSY/NONSEQ/SEQ)
//   hburst       - muxed address-phase hburst
//   hready       - bus hready
//   hgrant       - one-hot grant
//   hmaster      - address-phase owner index
//   hmaster_d    - data-phase owner index (hwdata mux select)
//   hmastlock    - current address-phase transfer is locked
module ahb2_arbiter #(
    parameter int unsigned N_MST       = 4,
    parameter int unsigned DEFAULT_MST = 0,
    parameter int unsigned MW          = $clog2(N_MST)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_MST-1:0] hbusreq,
    input  logic [N_MST-1:0] hlock,
    input  logic [1:0]       htrans,
    input  logic [2:0]       hburst,
    input  logic             hready,
    output logic [N_MST-1:0] hgrant,
    output logic [MW-1:0]    hmaster,
    output logic [MW-1:0]    hmaster_d,
    output logic             hmastlock
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    localparam logic [2:0] BU_WRAP4  = 3'd2;
    localparam logic [2:0] BU_INCR4  = 3'd3;
    localparam logic [2:0] BU_WRAP8  = 3'd4;
    localparam logic [2:0] BU_INCR8  = 3'd5;
    localparam logic [2:0] BU_WRAP16 = 3'd6;
    localparam logic [2:0] BU_INCR16 = 3'd7;

    localparam logic [N_MST-1:0] GRANT_RST = N_MST'(1) << DEFAULT_MST;

    logic [N_MST-1:0] hgrant_q,    hgrant_d;
    logic [MW-1:0]    hmaster_q,   hmaster_d_;
    logic [MW-1:0]    hmaster_d_q, hmaster_d_d;
    logic             hmastlock_q, hmastlock_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic [MW-1:0]    g_idx;
    logic [MW-1:0]    win;
    logic [MW-1:0]    cand;
    logic             found;
    logic             arb_point;

    // Index of the current grant holder.
    always_comb begin
        g_idx = '0;
        for (int unsigned i = 0; i < N_MST; i++) begin
            if (hgrant_q[i]) g_idx = MW'(i);
        end
    end

    // Remaining beats of the owner's fixed-length burst.
    always_comb begin
        cnt_d = cnt_q;
        if (hready) begin
            unique case (htrans)
                TR_NONSEQ: begin
                    unique case (hburst)
                        BU_WRAP4,  BU_INCR4:  cnt_d = CNT_W'(3);
                        BU_WRAP8,  BU_INCR8:  cnt_d = CNT_W'(7);
                        BU_WRAP16, BU_INCR16: cnt_d = CNT_W'(15);
                        default:              cnt_d = '0;
                    endcase
                end
                TR_SEQ:  if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                TR_BUSY: cnt_d = cnt_q;
                TR_IDLE: cnt_d = '0;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Round-robin search starting just after the current owner, owner last.
    always_comb begin
        win   = MW'(DEFAULT_MST);
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= N_MST; i++) begin
            cand = MW'((32'(g_idx) + i) % N_MST);
            if (!found && hbusreq[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign arb_point = hready && (cnt_d == '0) && !(hlock[g_idx] && hbusreq[g_idx]);

    // Next grant and address/data-phase owner pipeline.
    always_comb begin
        hgrant_d    = hgrant_q;
        hmaster_d_  = hmaster_q;
        hmaster_d_d = hmaster_d_q;
        hmastlock_d = hmastlock_q;
        if (arb_point) hgrant_d = N_MST'(1) << win;
        if (hready) begin
            hmaster_d_  = g_idx;
            hmastlock_d = hlock[g_idx];
            hmaster_d_d = hmaster_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hgrant_q    <= GRANT_RST;
            hmaster_q   <= MW'(DEFAULT_MST);
            hmaster_d_q <= MW'(DEFAULT_MST);
            hmastlock_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            hgrant_q    <= hgrant_d;
            hmaster_q   <= hmaster_d_;
            hmaster_d_q <= hmaster_d_d;
            hmastlock_q <= hmastlock_d;
            cnt_q       <= cnt_d;
        end
    end

    assign hgrant    = hgrant_q;
    assign hmaster   = hmaster_q;
    assign hmaster_d = hmaster_d_q;
    assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb2_arbiter.sv
// Scoreboard bench for ahb2_arbiter: a driver applies one directed vector per
// cycle and queues the hand-derived post-edge outputs; a monitor pops one
// entry after every rising edge and compares.
module tb_ahb2_arbiter;

    localparam int unsigned N_MST = 4;
    localparam int unsigned MW    = 2;

    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSQ = 2'd2, SEQ = 2'd3;
    localparam logic [2:0] SNG = 3'd0, INCR4 = 3'd3, INCR8 = 3'd5, INCR16 = 3'd7;

    typedef struct {
        string            name;
        logic [N_MST-1:0] g;
        logic [MW-1:0]    m;
        logic [MW-1:0]    md;
        logic             ml;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_MST-1:0] hbusreq = '0;
    logic [N_MST-1:0] hlock = '0;
    logic [1:0]       htrans = IDLE;
    logic [2:0]       hburst = SNG;
    logic             hready = 1'b1;
    logic [N_MST-1:0] hgrant;
    logic [MW-1:0]    hmaster;
    logic [MW-1:0]    hmaster_d;
    logic             hmastlock;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    ahb2_arbiter #(.N_MST(N_MST), .DEFAULT_MST(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmaster_d (hmaster_d),
        .hmastlock (hmastlock)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input string name, input logic rn, input logic [3:0] req,
                        input logic [3:0] lck, input logic [1:0] tr, input logic [2:0] bu,
                        input logic rdy, input logic [3:0] eg, input logic [1:0] em,
                        input logic [1:0] emd, input logic eml);
        exp_t e;
        @(negedge clk);
        rst_n   = rn;
        hbusreq = req;
        hlock   = lck;
        htrans  = tr;
        hburst  = bu;
        hready  = rdy;
        e.name = name; e.g = eg; e.m = em; e.md = emd; e.ml = eml;
        exp_q.push_back(e);
        n_vec++;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (hgrant !== e.g || hmaster !== e.m || hmaster_d !== e.md ||
                    hmastlock !== e.ml || !$onehot(hgrant)) begin
                    n_miss++;
                    $display("FAIL %s: got hgrant=%b hmaster=%0d hmaster_d=%0d hmastlock=%b, want hgrant=%b hmaster=%0d hmaster_d=%0d hmastlock=%b",
                             e.name, hgrant, hmaster, hmaster_d, hmastlock, e.g, e.m, e.md, e.ml);
                end
            end
        end
    end

    initial begin
        // Reset with busy inputs.
        step("rst0", 0, 4'b1111, 4'b1010, NSQ, INCR16, 1, 4'b0001, 0, 0, 0);
        step("rst1", 0, 4'b0110, 4'b0110, SEQ, INCR8,  1, 4'b0001, 0, 0, 0);

        // Round robin over m1..m3, single transfers.
        step("rr1", 1, 4'b1110, 4'b0000, NSQ, SNG, 1, 4'b0010, 0, 0, 0);
        step("rr2", 1, 4'b1110, 4'b0000, NSQ, SNG, 1, 4'b0100, 1, 0, 0);
        step("rr3", 1, 4'b1110, 4'b0000, NSQ, SNG, 1, 4'b1000, 2, 1, 0);
        step("rr4", 1, 4'b1110, 4'b0000, NSQ, SNG, 1, 4'b0010, 3, 2, 0);

        // m1 INCR4 with wait states and a BUSY while m2 requests.
        step("bst_nsq",  1, 4'b0110, 4'b0000, NSQ,  INCR4, 1, 4'b0010, 1, 3, 0);
        step("bst_w0",   1, 4'b0110, 4'b0000, SEQ,  INCR4, 0, 4'b0010, 1, 3, 0);
        step("bst_w1",   1, 4'b0110, 4'b0000, SEQ,  INCR4, 0, 4'b0010, 1, 3, 0);
        step("bst_seq1", 1, 4'b0110, 4'b0000, SEQ,  INCR4, 1, 4'b0010, 1, 1, 0);
        step("bst_busy", 1, 4'b0110, 4'b0000, BUSY, INCR4, 1, 4'b0010, 1, 1, 0);
        step("bst_seq2", 1, 4'b0110, 4'b0000, SEQ,  INCR4, 1, 4'b0010, 1, 1, 0);
        step("bst_last", 1, 4'b0110, 4'b0000, SEQ,  INCR4, 1, 4'b0100, 1, 1, 0);

        // m2 locked for six transfers against m0/m3 requests.
        step("lck1", 1, 4'b1101, 4'b0100, NSQ, SNG, 1, 4'b0100, 2, 1, 1);
        step("lck2", 1, 4'b1101, 4'b0100, NSQ, SNG, 1, 4'b0100, 2, 2, 1);
        step("lck3", 1, 4'b1101, 4'b0100, NSQ, SNG, 1, 4'b0100, 2, 2, 1);
        step("lck4", 1, 4'b1101, 4'b0100, NSQ, SNG, 1, 4'b0100, 2, 2, 1);
        step("lck5", 1, 4'b1101, 4'b0100, NSQ, SNG, 1, 4'b0100, 2, 2, 1);
        step("lck6", 1, 4'b1101, 4'b0100, NSQ, SNG, 1, 4'b0100, 2, 2, 1);
        step("unlck", 1, 4'b1101, 4'b0000, NSQ, SNG, 1, 4'b1000, 2, 2, 0);

        // m3 keeps bus when alone, then park on m0 and freeze on hready=0.
        step("m3own", 1, 4'b1000, 4'b0000, NSQ,  SNG, 1, 4'b1000, 3, 2, 0);
        step("park",  1, 4'b0000, 4'b0000, IDLE, SNG, 1, 4'b0001, 3, 3, 0);
        step("park2", 1, 4'b0000, 4'b0000, IDLE, SNG, 1, 4'b0001, 0, 3, 0);
        step("frz1",  1, 4'b0000, 4'b0000, IDLE, SNG, 0, 4'b0001, 0, 3, 0);
        step("frz2",  1, 4'b0000, 4'b0000, IDLE, SNG, 0, 4'b0001, 0, 3, 0);
        step("frz3",  1, 4'b0000, 4'b0000, IDLE, SNG, 0, 4'b0001, 0, 3, 0);
        step("thaw",  1, 4'b0000, 4'b0000, IDLE, SNG, 1, 4'b0001, 0, 0, 0);

        // m1 INCR8 terminated early by IDLE after three beats.
        step("et_gnt",  1, 4'b0010, 4'b0000, NSQ,  SNG,   1, 4'b0010, 0, 0, 0);
        step("et_nsq",  1, 4'b0011, 4'b0000, NSQ,  INCR8, 1, 4'b0010, 1, 0, 0);
        step("et_seq1", 1, 4'b0011, 4'b0000, SEQ,  INCR8, 1, 4'b0010, 1, 1, 0);
        step("et_seq2", 1, 4'b0011, 4'b0000, SEQ,  INCR8, 1, 4'b0010, 1, 1, 0);
        step("et_idle", 1, 4'b0011, 4'b0000, IDLE, INCR8, 1, 4'b0001, 1, 1, 0);

        // Reset in the middle of an m1 INCR16; counter must clear too.
        step("r_gnt",  1, 4'b0010, 4'b0000, NSQ, SNG,    1, 4'b0010, 0, 1, 0);
        step("r_nsq",  1, 4'b0110, 4'b0000, NSQ, INCR16, 1, 4'b0010, 1, 0, 0);
        step("r_seq",  1, 4'b0110, 4'b0000, SEQ, INCR16, 1, 4'b0010, 1, 1, 0);
        step("r_rst",  0, 4'b0110, 4'b0010, SEQ, INCR16, 1, 4'b0001, 0, 0, 0);
        step("r_post", 1, 4'b0100, 4'b0000, SEQ, INCR16, 1, 4'b0100, 0, 0, 0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_miss += exp_q.size();
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
